// File: rtl/aes_spi_block_ctrl_pkg.sv
// Shared constants for the AES block <-> 16-bit SPI master sequencer.
package aes_spi_pkg;

    localparam int SPI_WORD_W = 16;
    localparam int BLOCK_W    = 128;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_LOAD    = 3'd1;
    localparam state_t S_WAIT    = 3'd2;
    localparam state_t S_CAPTURE = 3'd3;
    localparam state_t S_GAP     = 3'd4;
    localparam state_t S_FINISH  = 3'd5;

endpackage

// File: rtl/aes_spi_block_ctrl_if.sv
// Block-side and SPI-master-side signals of the sequencer; slave = the sequencer.
interface aes_spi_block_ctrl_if #(
    parameter int WORDS = 8
);
    import aes_spi_pkg::*;

    logic                          blk_valid;
    logic                          blk_ready;
    logic [WORDS*SPI_WORD_W-1:0]   blk_in;
    logic                          res_valid;
    logic [WORDS*SPI_WORD_W-1:0]   res_out;
    logic                          err;
    logic [SPI_WORD_W-1:0]         spi_data_in;
    logic                          spi_data_valid;
    logic                          spi_done;
    logic [SPI_WORD_W-1:0]         spi_data_out;

    modport slave (
        input  blk_valid, blk_in, spi_done, spi_data_out,
        output blk_ready, res_valid, res_out, err, spi_data_in, spi_data_valid
    );

    modport master (
        output blk_valid, blk_in, spi_done, spi_data_out,
        input  blk_ready, res_valid, res_out, err, spi_data_in, spi_data_valid
    );

endinterface

// File: rtl/aes_spi_block_ctrl_spi_done_edge.sv
// Registered rising-edge detector on the SPI master's DONE.
module spi_done_edge (
    input  logic clock,
    input  logic rst_n,
    input  logic done,
    output logic rise
);

    logic done_q, done_d;

    always_comb done_d = done;

    always_ff @(posedge clock) begin
        if (!rst_n) done_q <= 1'b0;
        else        done_q <= done_d;
    end

    assign rise = done & ~done_q;

endmodule

// File: rtl/aes_spi_block_ctrl.sv
// Sends one block through the SPI master as WORDS word transfers and gathers MISO.
// Optional DONE watchdog enabled by defining SPI_TIMEOUT_EN.
module aes_spi_block_ctrl
    import aes_spi_pkg::*;
#(
    parameter int WORDS      = 8,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 64
) (
    input logic            clock,
    input logic            rst_n,
    aes_spi_block_ctrl_if.slave bus
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t                              state_q, state_d;
    logic [IW-1:0]                       idx_q, idx_d;
    logic [GW-1:0]                       gap_q, gap_d;
    logic [WORDS-1:0][SPI_WORD_W-1:0]    buf_q, buf_d;
    logic [WORDS-1:0][SPI_WORD_W-1:0]    res_q, res_d;
    logic                                done_rise;
    logic                                tmo_hit;

    spi_done_edge u_done_edge (
        .clock (clock),
        .rst_n (rst_n),
        .done  (bus.spi_done),
        .rise  (done_rise)
    );

`ifdef SPI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_q, tmo_d;

    // A DONE edge in the last allowed cycle still wins over the abort.
    assign tmo_hit = (state_q == S_WAIT) && !done_rise && (tmo_q == TMO_LAST);

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == S_LOAD)      tmo_d = '0;
        else if (state_q == S_WAIT) tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
    // No watchdog: WAIT holds until DONE, never fires.
    assign tmo_hit = (TIMEOUT < 0);
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        buf_d   = buf_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: if (bus.blk_valid) begin
                buf_d   = bus.blk_in;
                idx_d   = '0;
                state_d = S_LOAD;
            end
            S_LOAD: state_d = S_WAIT;
            S_WAIT: begin
                if (done_rise)    state_d = S_CAPTURE;
                else if (tmo_hit) state_d = S_IDLE;
            end
            // DATA_OUT settles on DONE's edge, so it is sampled one cycle later here.
            S_CAPTURE: begin
                res_d[idx_q] = bus.spi_data_out;
                if (idx_q == LAST_IDX) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? S_LOAD : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_LOAD;
                else                   gap_d   = gap_q + 1'b1;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            buf_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            buf_q   <= buf_d;
            res_q   <= res_d;
        end
    end

    assign bus.blk_ready      = (state_q == S_IDLE);
    assign bus.res_valid      = (state_q == S_FINISH);
    assign bus.res_out        = res_q;
    assign bus.err            = tmo_hit;
    assign bus.spi_data_valid = (state_q == S_LOAD);
    assign bus.spi_data_in    = (state_q == S_LOAD) ? buf_q[idx_q] : '0;

endmodule

// File: tb/tb_aes_spi_block_ctrl.sv
// Directed bench: three sequencers (GAP 2/0/5) each driving a loopback SPI master model.
module tb_aes_spi_block_ctrl;
    import aes_spi_pkg::*;

    localparam int NI  = 3;
    localparam int TMO = 20;

    logic clock = 1'b0;
    logic rst_n;
    always #5 clock = ~clock;

    logic [NI-1:0]             blk_valid, blk_ready, res_valid, err, dv, done_w;
    logic [NI-1:0][127:0]      blk_in, res_out;
    logic [NI-1:0][15:0]       d_in, d_out;
    logic [NI-1:0]             mdone, stray_done;

    for (genvar g = 0; g < NI; g++) begin : gi
        aes_spi_block_ctrl_if #(.WORDS(8)) bus ();
        assign bus.blk_valid    = blk_valid[g];
        assign bus.blk_in       = blk_in[g];
        assign bus.spi_done     = done_w[g];
        assign bus.spi_data_out = d_out[g];
        assign blk_ready[g]     = bus.blk_ready;
        assign res_valid[g]     = bus.res_valid;
        assign res_out[g]       = bus.res_out;
        assign err[g]           = bus.err;
        assign d_in[g]          = bus.spi_data_in;
        assign dv[g]            = bus.spi_data_valid;
        assign done_w[g]        = mdone[g] | stray_done[g];

        aes_spi_block_ctrl #(
            .WORDS      (8),
            .GAP_CYCLES ((g == 0) ? 2 : ((g == 1) ? 0 : 5)),
            .TIMEOUT    (TMO)
        ) dut (
            .clock (clock),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    int cyc = 0;
    always @(posedge clock) cyc++;

    // SPI master model: DONE 17 cycles after data_valid, MISO = MOSI, no reset.
    int          cnt[NI]      = '{default: 0};
    int          hold[NI]     = '{default: 0};
    int          hold_len[NI] = '{default: 1};
    bit          mute[NI]     = '{default: 1'b0};
    logic [15:0] lat[NI]      = '{default: 16'h0};
    initial begin mdone = '0; d_out = '0; end

    always @(negedge clock) begin
        for (int g = 0; g < NI; g++) begin
            if (cnt[g] > 0) begin
                cnt[g]--;
                if (cnt[g] == 0) begin
                    mdone[g] = 1'b1;
                    d_out[g] = lat[g];
                    hold[g]  = hold_len[g];
                end
            end else if (hold[g] > 0) begin
                hold[g]--;
                if (hold[g] == 0) mdone[g] = 1'b0;
            end
            if (dv[g] && !mute[g]) begin
                lat[g] = d_in[g];
                cnt[g] = 17;
            end
        end
    end

    // Event log, sampled mid-cycle.
    int           dv_cyc[NI][256];
    logic [15:0]  dv_word[NI][256];
    int           rv_cyc[NI][256];
    logic [127:0] rv_res[NI][256];
    int           dv_n[NI]  = '{default: 0};
    int           rv_n[NI]  = '{default: 0};
    int           err_n[NI] = '{default: 0};

    always @(negedge clock) begin
        for (int g = 0; g < NI; g++) begin
            if (dv[g] && dv_n[g] < 256) begin
                dv_cyc[g][dv_n[g]]  = cyc;
                dv_word[g][dv_n[g]] = d_in[g];
                dv_n[g]++;
            end
            if (res_valid[g] && rv_n[g] < 256) begin
                rv_cyc[g][rv_n[g]] = cyc;
                rv_res[g][rv_n[g]] = res_out[g];
                rv_n[g]++;
            end
            if (err[g]) err_n[g]++;
        end
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_rv(input int g, input string name);
        int t;
        t = 0;
        while (!res_valid[g] && t < 500) begin @(negedge clock); t++; end
        chki(name, int'(t < 500), 1);
    endtask

    task automatic run_block(input int g, input logic [127:0] blk,
                             output int acc_c, output int rv_i, output int dv_i);
        int t;
        @(negedge clock);
        dv_i         = dv_n[g];
        rv_i         = rv_n[g];
        blk_in[g]    = blk;
        blk_valid[g] = 1'b1;
        t = 0;
        while (!blk_ready[g] && t < 500) begin @(negedge clock); t++; end
        acc_c = cyc;
        @(posedge clock);
        #1 blk_valid[g] = 1'b0;
        wait_rv(g, "block_completes");
        repeat (2) @(negedge clock);
    endtask

    typedef struct {
        int           inst;
        logic [127:0] blk;
        logic [15:0]  w0;
        logic [15:0]  w7;
        int           lat;
        int           sp;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc, rvi, dvi, g, t, busy_bad, c0, rv0, e0;
        logic [127:0] r0;

        tbl[0] = '{0, 128'h000102030405060708090A0B0C0D0E0F, 16'h0E0F, 16'h0001, 167, 21};
        tbl[1] = '{0, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 16'hDEF0, 16'hDEAD, 167, 21};
        tbl[2] = '{1, 128'hFFFF0000_A5A55A5A_0F0FF0F0_13572468, 16'h2468, 16'hFFFF, 153, 19};
        tbl[3] = '{2, 128'h0123456789ABCDEFFEDCBA9876543210, 16'h3210, 16'h0123, 188, 24};
        tbl[4] = '{0, {128{1'b1}}, 16'hFFFF, 16'hFFFF, 167, 21};

        rst_n      = 1'b0;
        blk_valid  = '0;
        blk_in     = '0;
        stray_done = '0;
        repeat (3) @(negedge clock);
        chki("rst_blk_ready", int'(blk_ready[0]), 1);
        chki("rst_res_valid", int'(res_valid[0]), 0);
        chki("rst_err", int'(err[0]), 0);
        chki("rst_data_valid", int'(dv[0]), 0);
        chk("rst_data_in", d_in[0], 128'h0);
        chk("rst_res_out", res_out[0], 128'h0);
        rst_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 5; i++) begin
            g = tbl[i].inst;
            run_block(g, tbl[i].blk, acc, rvi, dvi);
            chk("res_out", rv_res[g][rvi], tbl[i].blk);
            chki("latency", rv_cyc[g][rvi] - acc, tbl[i].lat);
            chki("res_valid_pulses", rv_n[g] - rvi, 1);
            chki("data_valid_count", dv_n[g] - dvi, 8);
            chki("first_data_valid", dv_cyc[g][dvi] - acc, 1);
            chk("first_word", dv_word[g][dvi], tbl[i].w0);
            chk("last_word", dv_word[g][dvi + 7], tbl[i].w7);
            for (int k = 0; k < 7; k++)
                chki("word_spacing", dv_cyc[g][dvi + k + 1] - dv_cyc[g][dvi + k], tbl[i].sp);
            for (int k = 0; k < 8; k++)
                chk("word_order", dv_word[g][dvi + k], tbl[i].blk[16*k +: 16]);
        end

        // Busy rejection: second block held on blk_valid during the first.
        @(negedge clock);
        rvi          = rv_n[0];
        blk_in[0]    = 128'h11112222333344445555666677778888;
        blk_valid[0] = 1'b1;
        @(posedge clock);
        #1 blk_in[0] = 128'h9999AAAABBBBCCCCDDDDEEEEFFFF0000;
        busy_bad = 0;
        t = 0;
        @(negedge clock);
        while (!res_valid[0] && t < 500) begin
            if (blk_ready[0]) busy_bad++;
            @(negedge clock);
            t++;
        end
        chki("busy_ready_low", busy_bad, 0);
        chk("busy_first_res", res_out[0], 128'h11112222333344445555666677778888);
        @(negedge clock);
        chki("busy_accept_after_rv", int'(blk_ready[0]), 1);
        @(posedge clock);
        #1 blk_valid[0] = 1'b0;
        repeat (10) @(negedge clock);
        chk("busy_res_held", res_out[0], 128'h11112222333344445555666677778888);
        wait_rv(0, "busy_second_completes");
        chk("busy_second_res", res_out[0], 128'h9999AAAABBBBCCCCDDDDEEEEFFFF0000);
        repeat (2) @(negedge clock);

        // Stray DONE in IDLE, then DONE stuck high 3 cycles per word.
        @(negedge clock);
        r0 = res_out[0];
        dvi = dv_n[0];
        stray_done[0] = 1'b1;
        @(negedge clock);
        stray_done[0] = 1'b0;
        repeat (4) @(negedge clock);
        chk("stray_no_capture", res_out[0], r0);
        chki("stray_no_load", dv_n[0] - dvi, 0);
        chki("stray_stays_idle", int'(blk_ready[0]), 1);
        hold_len[0] = 3;
        run_block(0, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, acc, rvi, dvi);
        hold_len[0] = 1;
        chk("stuck_res_out", rv_res[0][rvi], 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0);
        chki("stuck_words", dv_n[0] - dvi, 8);
        chki("stuck_latency", rv_cyc[0][rvi] - acc, 167);

        // Reset one cycle after word 3's CAPTURE.
        @(negedge clock);
        blk_in[0]    = 128'hCAFE0001CAFE0002CAFE0003CAFE0004;
        blk_valid[0] = 1'b1;
        @(posedge clock);
        #1 blk_valid[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            t = 0;
            while (!dv[0] && t < 100) begin @(negedge clock); t++; end
        end
        repeat (19) @(negedge clock);
        rv0   = rv_n[0];
        rst_n = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        chki("midrst_ready", int'(blk_ready[0]), 1);
        chki("midrst_no_valid", int'(dv[0]), 0);
        chk("midrst_res_dropped", res_out[0], 128'h0);
        repeat (40) @(negedge clock);
        chki("midrst_no_res_valid", rv_n[0] - rv0, 0);
        run_block(0, 128'h76543210FEDCBA98_0011223344556677, acc, rvi, dvi);
        chk("midrst_next_res", rv_res[0][rvi], 128'h76543210FEDCBA980011223344556677);
        chki("midrst_next_latency", rv_cyc[0][rvi] - acc, 167);

`ifdef SPI_TIMEOUT_EN
        // Master never answers: abort exactly TMO cycles after data_valid.
        mute[0] = 1'b1;
        @(negedge clock);
        rv0          = rv_n[0];
        e0           = err_n[0];
        blk_in[0]    = 128'h5555AAAA5555AAAA5555AAAA5555AAAA;
        blk_valid[0] = 1'b1;
        @(posedge clock);
        #1 blk_valid[0] = 1'b0;
        @(negedge clock);
        t = 0;
        while (!dv[0] && t < 100) begin @(negedge clock); t++; end
        c0 = cyc;
        t = 0;
        while (!err[0] && t < 200) begin @(negedge clock); t++; end
        chki("tmo_err_cycle", cyc - c0, TMO);
        @(negedge clock);
        chki("tmo_err_pulse", int'(err[0]), 0);
        chki("tmo_ready_after", int'(blk_ready[0]), 1);
        repeat (3) @(negedge clock);
        chki("tmo_no_res_valid", rv_n[0] - rv0, 0);
        chki("tmo_err_count", err_n[0] - e0, 1);
        mute[0] = 1'b0;
`else
        chki("err_never_pulses", err_n[0] + err_n[1] + err_n[2], 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
